// File: rtl/multicyc_cu.sv
// Multicycle MIPS control unit.
// Runs each instruction through three to five states and drives the
// datapath muxes, register enables and memory strobes from the current
// state. Also handles the memory-ready handshake, traps illegal opcodes
// and counts retired instructions.
module multicyc_cu #(
    parameter int ALUOP_W = 4,
    parameter int MEM_HS  = 1,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic               iord,
    output logic               ir_we,
    output logic               mem_rd,
    output logic               mem_wr,
    output logic               reg_we,
    output logic               wreg_dst_sel,
    output logic               wrbck_sel,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [ALUOP_W-1:0] aluop,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   retired,
    output logic [3:0]         state_dbg
);

    // ALU operation codes shared with the ALU decoder
    localparam logic [ALUOP_W-1:0] ALUOP_ADD  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALUOP_ADDU = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALUOP_SUB  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALUOP_RR   = ALUOP_W'(15);

    localparam logic [5:0] OP_RR    = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BR    = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] retired_reg;
    logic             illegal_reg;
    logic             rdy;
    logic             retire;

    // Without the handshake every memory access completes in one cycle
    assign rdy = (MEM_HS != 0) ? mem_ready : 1'b1;

    // State, retire counter and sticky trap flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            retired_reg <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (retire)
                retired_reg <= retired_reg + CNT_W'(1);
            if (state_next == S_TRAP)
                illegal_reg <= 1'b1;
        end
    end

    // Next-state decode; retire marks the last cycle of a completed instruction
    always_comb begin
        state_next = state_reg;
        retire     = 1'b0;
        case (state_reg)
            S_FETCH:  if (rdy) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:      state_next = S_MEMADR;
                    OP_RR:             state_next = S_EXEC;
                    OP_BR:             state_next = S_BRANCH;
                    OP_ADDI, OP_ADDIU: state_next = S_IMMEX;
                    OP_J:              state_next = S_JUMP;
                    default:           state_next = S_TRAP;
                endcase
            end
            S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (rdy) state_next = S_MEMWB;
            S_MEMWR: begin
                if (rdy) begin
                    state_next = S_FETCH;
                    retire     = 1'b1;
                end
            end
            S_EXEC:   state_next = S_ALUWB;
            S_IMMEX:  state_next = S_IMMWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: begin
                state_next = S_FETCH;
                retire     = 1'b1;
            end
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_FETCH;
        endcase
    end

    // Moore output decode, gated by rdy/zero where noted; reset blanks everything
    always_comb begin
        pc_we        = 1'b0;
        pc_src       = 2'b00;
        iord         = 1'b0;
        ir_we        = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        reg_we       = 1'b0;
        wreg_dst_sel = 1'b0;
        wrbck_sel    = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        aluop        = ALUOP_ADD;
        case (state_reg)
            S_FETCH: begin
                mem_rd  = 1'b1;
                alusrcb = 2'b01;
                ir_we   = rdy;
                pc_we   = rdy;
            end
            S_DECODE: alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD: begin
                iord   = 1'b1;
                mem_rd = 1'b1;
            end
            S_MEMWB: begin
                reg_we    = 1'b1;
                wrbck_sel = 1'b1;
            end
            S_MEMWR: begin
                iord   = 1'b1;
                mem_wr = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_RR;
            end
            S_ALUWB: begin
                reg_we       = 1'b1;
                wreg_dst_sel = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pc_src  = 2'b01;
                pc_we   = zero;
            end
            S_IMMEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = (opcode == OP_ADDIU) ? ALUOP_ADDU : ALUOP_ADD;
            end
            S_IMMWB:  reg_we = 1'b1;
            S_JUMP: begin
                pc_src = 2'b10;
                pc_we  = 1'b1;
            end
            S_TRAP:   aluop = ALUOP_ADD;
            default:  aluop = '0;
        endcase
        if (rst) begin
            pc_we        = 1'b0;
            pc_src       = 2'b00;
            iord         = 1'b0;
            ir_we        = 1'b0;
            mem_rd       = 1'b0;
            mem_wr       = 1'b0;
            reg_we       = 1'b0;
            wreg_dst_sel = 1'b0;
            wrbck_sel    = 1'b0;
            alusrca      = 1'b0;
            alusrcb      = 2'b00;
            aluop        = '0;
        end
    end

    assign illegal_op = illegal_reg & ~rst;
    assign retired    = rst ? '0 : retired_reg;
    assign state_dbg  = rst ? 4'd0 : state_reg;

endmodule

// File: tb/tb_multicyc_cu.sv
// Directed bench for multicyc_cu: one instance without the memory handshake
// and one with it, each driven through hand-written instruction sequences.
module tb_multicyc_cu;

    localparam logic [3:0] A_ADD  = 4'd2;
    localparam logic [3:0] A_ADDU = 4'd3;
    localparam logic [3:0] A_SUB  = 4'd6;
    localparam logic [3:0] A_RR   = 4'd15;

    // Field order: pc_we, pc_src, iord, ir_we, mem_rd, mem_wr, reg_we,
    //              wreg_dst_sel, wrbck_sel, alusrca, alusrcb, aluop, illegal_op, state_dbg
    localparam logic [21:0] E_RESET      = 22'd0;
    localparam logic [21:0] E_FETCH_RDY  = {1'b1,2'b00,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,A_ADD, 1'b0,4'd0};
    localparam logic [21:0] E_FETCH_WAIT = {1'b0,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,A_ADD, 1'b0,4'd0};
    localparam logic [21:0] E_DECODE     = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,A_ADD, 1'b0,4'd1};
    localparam logic [21:0] E_MEMADR     = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,A_ADD, 1'b0,4'd2};
    localparam logic [21:0] E_MEMRD      = {1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,A_ADD, 1'b0,4'd3};
    localparam logic [21:0] E_MEMWB      = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,A_ADD, 1'b0,4'd4};
    localparam logic [21:0] E_MEMWR      = {1'b0,2'b00,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,A_ADD, 1'b0,4'd5};
    localparam logic [21:0] E_EXEC       = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,A_RR,  1'b0,4'd6};
    localparam logic [21:0] E_ALUWB      = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,A_ADD, 1'b0,4'd7};
    localparam logic [21:0] E_BR_T       = {1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,A_SUB, 1'b0,4'd8};
    localparam logic [21:0] E_BR_NT      = {1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,A_SUB, 1'b0,4'd8};
    localparam logic [21:0] E_IMMEX_U    = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,A_ADDU,1'b0,4'd9};
    localparam logic [21:0] E_IMMEX_S    = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,A_ADD, 1'b0,4'd9};
    localparam logic [21:0] E_IMMWB      = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,A_ADD, 1'b0,4'd10};
    localparam logic [21:0] E_JUMP       = {1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,A_ADD, 1'b0,4'd11};
    localparam logic [21:0] E_TRAP       = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,A_ADD, 1'b1,4'd12};

    logic clk;
    int   checks;
    int   errors;

    // Instance 0: MEM_HS = 0
    logic        rst0, zero0, mr0;
    logic [5:0]  op0;
    logic        pc_we0, iord0, ir_we0, mem_rd0, mem_wr0, reg_we0, wreg_dst_sel0, wrbck_sel0, alusrca0, illegal_op0;
    logic [1:0]  pc_src0, alusrcb0;
    logic [3:0]  aluop0, state_dbg0;
    logic [31:0] retired0;
    logic [21:0] ctl0;

    // Instance 1: MEM_HS = 1
    logic        rst1, zero1, mr1;
    logic [5:0]  op1;
    logic        pc_we1, iord1, ir_we1, mem_rd1, mem_wr1, reg_we1, wreg_dst_sel1, wrbck_sel1, alusrca1, illegal_op1;
    logic [1:0]  pc_src1, alusrcb1;
    logic [3:0]  aluop1, state_dbg1;
    logic [31:0] retired1;
    logic [21:0] ctl1;

    assign ctl0 = {pc_we0, pc_src0, iord0, ir_we0, mem_rd0, mem_wr0, reg_we0, wreg_dst_sel0,
                   wrbck_sel0, alusrca0, alusrcb0, aluop0, illegal_op0, state_dbg0};
    assign ctl1 = {pc_we1, pc_src1, iord1, ir_we1, mem_rd1, mem_wr1, reg_we1, wreg_dst_sel1,
                   wrbck_sel1, alusrca1, alusrcb1, aluop1, illegal_op1, state_dbg1};

    multicyc_cu #(.ALUOP_W(4), .MEM_HS(0), .CNT_W(32)) dut0 (
        .clk(clk), .rst(rst0), .opcode(op0), .zero(zero0), .mem_ready(mr0),
        .pc_we(pc_we0), .pc_src(pc_src0), .iord(iord0), .ir_we(ir_we0),
        .mem_rd(mem_rd0), .mem_wr(mem_wr0), .reg_we(reg_we0),
        .wreg_dst_sel(wreg_dst_sel0), .wrbck_sel(wrbck_sel0), .alusrca(alusrca0),
        .alusrcb(alusrcb0), .aluop(aluop0), .illegal_op(illegal_op0),
        .retired(retired0), .state_dbg(state_dbg0)
    );

    multicyc_cu #(.ALUOP_W(4), .MEM_HS(1), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst1), .opcode(op1), .zero(zero1), .mem_ready(mr1),
        .pc_we(pc_we1), .pc_src(pc_src1), .iord(iord1), .ir_we(ir_we1),
        .mem_rd(mem_rd1), .mem_wr(mem_wr1), .reg_we(reg_we1),
        .wreg_dst_sel(wreg_dst_sel1), .wrbck_sel(wrbck_sel1), .alusrca(alusrca1),
        .alusrcb(alusrcb1), .aluop(aluop1), .illegal_op(illegal_op1),
        .retired(retired1), .state_dbg(state_dbg1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rst1 = 1'b1;
        step(); step();
        #1;
        checks++;
        if (ctl0 !== E_RESET) begin errors++; $display("FAIL reset_ctl0 got=%h exp=%h", ctl0, E_RESET); end
        checks++;
        if (ctl1 !== E_RESET) begin errors++; $display("FAIL reset_ctl1 got=%h exp=%h", ctl1, E_RESET); end
        checks++;
        if (retired0 !== 32'd0) begin errors++; $display("FAIL reset_retired0 got=%0d exp=0", retired0); end
        step();
        rst0 = 1'b0; rst1 = 1'b0;
        $display("reset: released");
    endtask

    // RR on the no-handshake instance; mem_ready held low to show it is ignored
    task automatic test_rr();
        logic [21:0] seq [4];
        seq = '{E_FETCH_RDY, E_DECODE, E_EXEC, E_ALUWB};
        op0 = 6'h00;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ctl0 !== seq[i]) begin errors++; $display("FAIL rr_step%0d got=%h exp=%h", i, ctl0, seq[i]); end
            step();
        end
        #1;
        checks++;
        if (ctl0 !== E_FETCH_RDY || retired0 !== 32'd1)
            begin errors++; $display("FAIL rr_end got=%h/%0d exp=%h/1", ctl0, retired0, E_FETCH_RDY); end
        $display("rr: retired=%0d", retired0);
    endtask

    task automatic test_lw_nohs();
        logic [21:0] seq [5];
        seq = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB};
        op0 = 6'h23;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (ctl0 !== seq[i]) begin errors++; $display("FAIL lw0_step%0d got=%h exp=%h", i, ctl0, seq[i]); end
            step();
        end
        #1;
        checks++;
        if (ctl0 !== E_FETCH_RDY || retired0 !== 32'd2)
            begin errors++; $display("FAIL lw0_end got=%h/%0d exp=%h/2", ctl0, retired0, E_FETCH_RDY); end
        $display("lw no-hs: retired=%0d", retired0);
    endtask

    task automatic test_branch();
        logic [21:0] seq [3];
        op0 = 6'h04;
        for (int pass = 0; pass < 2; pass++) begin
            zero0 = (pass == 0);
            seq = '{E_FETCH_RDY, E_DECODE, (pass == 0) ? E_BR_T : E_BR_NT};
            for (int i = 0; i < 3; i++) begin
                #1;
                checks++;
                if (ctl0 !== seq[i]) begin errors++; $display("FAIL br%0d_step%0d got=%h exp=%h", pass, i, ctl0, seq[i]); end
                step();
            end
            #1;
            checks++;
            if (ctl0 !== E_FETCH_RDY || retired0 !== 32'(3 + pass))
                begin errors++; $display("FAIL br%0d_end got=%h/%0d exp=%h/%0d", pass, ctl0, retired0, E_FETCH_RDY, 3 + pass); end
            $display("branch zero=%0b: retired=%0d", zero0, retired0);
        end
        zero0 = 1'b0;
    endtask

    task automatic test_addiu_j();
        logic [21:0] seq_i [4];
        logic [21:0] seq_j [3];
        seq_i = '{E_FETCH_RDY, E_DECODE, E_IMMEX_U, E_IMMWB};
        seq_j = '{E_FETCH_RDY, E_DECODE, E_JUMP};
        op0 = 6'h09;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ctl0 !== seq_i[i]) begin errors++; $display("FAIL addiu_step%0d got=%h exp=%h", i, ctl0, seq_i[i]); end
            step();
        end
        op0 = 6'h02;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (ctl0 !== seq_j[i]) begin errors++; $display("FAIL j_step%0d got=%h exp=%h", i, ctl0, seq_j[i]); end
            step();
        end
        #1;
        checks++;
        if (retired0 !== 32'd6) begin errors++; $display("FAIL addiu_j_retired got=%0d exp=6", retired0); end
        seq_i = '{E_FETCH_RDY, E_DECODE, E_IMMEX_S, E_IMMWB};
        op0 = 6'h08;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ctl0 !== seq_i[i]) begin errors++; $display("FAIL addi_step%0d got=%h exp=%h", i, ctl0, seq_i[i]); end
            step();
        end
        #1;
        checks++;
        if (ctl0 !== E_FETCH_RDY || retired0 !== 32'd7)
            begin errors++; $display("FAIL addi_end got=%h/%0d exp=%h/7", ctl0, retired0, E_FETCH_RDY); end
        $display("addiu/j/addi: retired=%0d", retired0);
    endtask

    task automatic test_trap();
        op0 = 6'h3F;
        #1;
        checks++;
        if (ctl0 !== E_FETCH_RDY) begin errors++; $display("FAIL trap_fetch got=%h exp=%h", ctl0, E_FETCH_RDY); end
        step();
        #1;
        checks++;
        if (ctl0 !== E_DECODE) begin errors++; $display("FAIL trap_decode got=%h exp=%h", ctl0, E_DECODE); end
        step();
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (ctl0 !== E_TRAP || retired0 !== 32'd7)
                begin errors++; $display("FAIL trap_hold%0d got=%h/%0d exp=%h/7", i, ctl0, retired0, E_TRAP); end
            step();
        end
        rst0 = 1'b1;
        #1;
        checks++;
        if (ctl0 !== E_RESET || retired0 !== 32'd0)
            begin errors++; $display("FAIL trap_rst got=%h/%0d exp=%h/0", ctl0, retired0, E_RESET); end
        step();
        rst0 = 1'b0;
        #1;
        checks++;
        if (ctl0 !== E_FETCH_RDY || retired0 !== 32'd0)
            begin errors++; $display("FAIL trap_after got=%h/%0d exp=%h/0", ctl0, retired0, E_FETCH_RDY); end
        $display("trap: cleared by reset, illegal_op=%0b", illegal_op0);
    endtask

    // LW with two FETCH waits and three MEMRD waits: 10 cycles
    task automatic test_lw_hs();
        logic [21:0] seq [10];
        logic        rdy_seq [10];
        seq     = '{E_FETCH_WAIT, E_FETCH_WAIT, E_FETCH_RDY, E_DECODE, E_MEMADR,
                    E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};
        rdy_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        op1 = 6'h23;
        #1;
        checks++;
        if (retired1 !== 32'd0) begin errors++; $display("FAIL lw1_start retired got=%0d exp=0", retired1); end
        for (int i = 0; i < 10; i++) begin
            mr1 = rdy_seq[i];
            #1;
            checks++;
            if (ctl1 !== seq[i]) begin errors++; $display("FAIL lw1_step%0d got=%h exp=%h", i, ctl1, seq[i]); end
            step();
        end
        mr1 = 1'b0;
        #1;
        checks++;
        if (ctl1 !== E_FETCH_WAIT || retired1 !== 32'd1)
            begin errors++; $display("FAIL lw1_end got=%h/%0d exp=%h/1", ctl1, retired1, E_FETCH_WAIT); end
        $display("lw hs: retired=%0d", retired1);
    endtask

    // SW completing on the first MEMWR cycle retires through MEMWR
    task automatic test_back_to_back();
        logic [21:0] seq [4];
        logic        rdy_seq [4];
        seq     = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMWR};
        rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1};
        op1 = 6'h2B;
        for (int i = 0; i < 4; i++) begin
            mr1 = rdy_seq[i];
            #1;
            checks++;
            if (ctl1 !== seq[i]) begin errors++; $display("FAIL sw_step%0d got=%h exp=%h", i, ctl1, seq[i]); end
            step();
        end
        mr1 = 1'b0;
        #1;
        checks++;
        if (ctl1 !== E_FETCH_WAIT || retired1 !== 32'd2)
            begin errors++; $display("FAIL sw_end got=%h/%0d exp=%h/2", ctl1, retired1, E_FETCH_WAIT); end
        $display("sw back-to-back: retired=%0d", retired1);
    endtask

    // SW aborted by reset on its second MEMWR wait cycle, with mem_ready also high
    task automatic test_sw_rst();
        logic [21:0] seq [4];
        logic        rdy_seq [4];
        seq     = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMWR};
        rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b0};
        op1 = 6'h2B;
        for (int i = 0; i < 4; i++) begin
            mr1 = rdy_seq[i];
            #1;
            checks++;
            if (ctl1 !== seq[i]) begin errors++; $display("FAIL swrst_step%0d got=%h exp=%h", i, ctl1, seq[i]); end
            step();
        end
        rst1 = 1'b1;
        mr1  = 1'b1;
        #1;
        checks++;
        if (ctl1 !== E_RESET || retired1 !== 32'd0)
            begin errors++; $display("FAIL swrst_during got=%h/%0d exp=%h/0", ctl1, retired1, E_RESET); end
        step();
        rst1 = 1'b0;
        mr1  = 1'b0;
        #1;
        checks++;
        if (ctl1 !== E_FETCH_WAIT || retired1 !== 32'd0)
            begin errors++; $display("FAIL swrst_after got=%h/%0d exp=%h/0", ctl1, retired1, E_FETCH_WAIT); end
        $display("sw reset abort: state=%0d retired=%0d", state_dbg1, retired1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst0 = 1'b1; zero0 = 1'b0; mr0 = 1'b0; op0 = 6'h00;
        rst1 = 1'b1; zero1 = 1'b0; mr1 = 1'b0; op1 = 6'h00;
        test_reset();
        test_rr();
        test_lw_nohs();
        test_branch();
        test_addiu_j();
        test_trap();
        test_lw_hs();
        test_back_to_back();
        test_sw_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
